load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit_byte_lane_unit.sv | 42 ++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared access-size, exception-cause and FSM state encodings.
// Revision: 1.0
`default_nettype none

package load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_byte_lane_unit.sv
// byte_lane_unit: little-endian load extraction/extension and store lane merge.
// Revision: 1.0
`default_nettype none

module byte_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = i_word;
    case (i_size)
      SIZE_BYTE: o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:   o_load_data = i_word;
    endcase

    // Merge replaces only the addressed lane(s) of the previously read word.
    o_merge_data = i_word;
    case (i_size)
      SIZE_BYTE: o_merge_data[{i_offset, 3'b000} +: 8]        = i_wdata[7:0];
      SIZE_HALF: o_merge_data[{i_offset[1], 4'b0000} +: 16]   = i_wdata[15:0];
      default:   o_merge_data = i_wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: MEM stage with 1-cycle loads, read-modify-write sub-word stores, exceptions.
// Revision: 1.0
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall,
  output logic [31:0] dm_address,
  output logic        dm_write_enable,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam logic [31:0] c_depth_words = 32'(DEPTH_WORDS);

  lsu_state_t  r_state;
  logic [29:0] r_word_idx;
  logic [31:0] r_word;
  logic [31:0] r_wdata;
  logic [1:0]  r_offset;
  logic [1:0]  r_size;

  logic        w_is_mem;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  logic        w_exc;
  logic [1:0]  w_cause;
  logic        w_store_ok;
  logic        w_word_store;
  logic        w_sub_store;
  logic        w_merge;
  logic [31:0] w_bl_word;
  logic [1:0]  w_bl_offset;
  logic [1:0]  w_bl_size;
  logic        w_bl_unsigned;
  logic [31:0] w_bl_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  always_comb begin
    w_is_mem   = ex_mem_read | ex_mem_write;
    w_illegal  = w_is_mem && ((ex_size == SIZE_RSVD) || (ex_mem_read && ex_mem_write));
    w_misalign = w_is_mem && (((ex_size == SIZE_HALF) && ex_addr[0]) ||
                              ((ex_size == SIZE_WORD) && (ex_addr[1:0] != 2'b00)));
    w_range    = w_is_mem && ({2'b00, ex_addr[31:2]} >= c_depth_words);

    w_cause = CAUSE_NONE;
    if (w_illegal)       w_cause = CAUSE_ILLEGAL;
    else if (w_misalign) w_cause = CAUSE_MISALIGN;
    else if (w_range)    w_cause = CAUSE_RANGE;

    w_exc        = ex_valid && (w_cause != CAUSE_NONE);
    w_store_ok   = ex_valid && ex_mem_write && !w_exc;
    w_word_store = w_store_ok && (ex_size == SIZE_WORD);
    w_sub_store  = w_store_ok && (ex_size != SIZE_WORD);
    w_merge      = (r_state == ST_MERGE);
  end

  // The lane unit sees the live load request in IDLE and the captured store in MERGE.
  always_comb begin
    w_bl_word     = w_merge ? r_word   : dm_read_data;
    w_bl_offset   = w_merge ? r_offset : ex_addr[1:0];
    w_bl_size     = w_merge ? r_size   : ex_size;
    w_bl_unsigned = w_merge ? 1'b0     : ex_unsigned;
    w_bl_wdata    = w_merge ? r_wdata  : ex_wdata;
  end

  byte_lane_unit u_byte_lane_unit (
    .i_word       (w_bl_word),
    .i_offset     (w_bl_offset),
    .i_size       (w_bl_size),
    .i_unsigned   (w_bl_unsigned),
    .i_wdata      (w_bl_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_comb begin
    stall           = !rst && !w_merge && w_sub_store;
    dm_write_enable = !rst && (w_merge || w_word_store);
    dm_address      = w_merge ? {2'b00, r_word_idx} : {2'b00, ex_addr[31:2]};
    dm_write_data   = w_merge ? w_merge_data : ex_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_word_idx   <= '0;
      r_word       <= '0;
      r_wdata      <= '0;
      r_offset     <= '0;
      r_size       <= SIZE_BYTE;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_cause    <= CAUSE_NONE;
      exc_addr     <= '0;
    end else begin
      exc_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
          if (ex_valid) begin
            if (w_exc) begin
              exc_valid    <= 1'b1;
              exc_cause    <= w_cause;
              exc_addr     <= ex_addr;
              wb_valid     <= 1'b1;
            end else if (ex_mem_read) begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
              wb_data      <= w_load_data;
            end else if (w_sub_store) begin
              r_state    <= ST_MERGE;
              r_word_idx <= ex_addr[31:2];
              r_word     <= dm_read_data;
              r_offset   <= ex_addr[1:0];
              r_size     <= ex_size;
              r_wdata    <= ex_wdata;
            end else if (ex_mem_write) begin
              wb_valid <= 1'b1;
            end else begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
              wb_data      <= ex_alu_result;
            end
          end
        end
        ST_MERGE: begin
          wb_valid     <= 1'b1;
          wb_reg_write <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
